tt_cpu_prog_mem_responder: RTL
==============================

Name: tt_cpu_prog_mem_responder

Overview:
Memory-side responder for the 6-bit TinyTapeout accumulator CPU. The CPU presents a fetch address or a display word on its 8-bit output bus; this block answers fetches from a host-loadable 64x6 program store and captures display words. It also sequences the CPU's synchronous active-high reset around program loading. The block sits on the board/harness side, wired to the CPU's io_out, io_in[7:2] and io_in[1].

Parameters:
ADDR_W, 6, program store address width (store depth = 2**ADDR_W).
DATA_W, 6, program word and display value width.
RELEASE_CYCLES, 4, clocks cpu_reset stays high after leaving reset or load mode (minimum 1).
OUT_CNT_W, 8, width of the display-event counter.

Ports:
clk  in  1  system clock, shared with the CPU
reset_n  in  1  asynchronous active-low reset
cpu_bus  in  8  CPU output bus: 2'b00 + address = fetch request; 2'b10 + value = display word
mem_data  out  DATA_W  fetch response to the CPU data input
cpu_reset  out  1  synchronous active-high reset to the CPU
load_mode  in  1  host holds high to load the program store
load_valid  in  1  one-cycle strobe: write load_data at load_addr
load_data  in  DATA_W  program word to write
load_addr  out  ADDR_W  next program store write address
out_value  out  DATA_W  last captured display value
out_valid  out  1  one-cycle pulse when out_value is updated
out_count  out  OUT_CNT_W  number of display events captured since reset

Behaviour:
- Reset (reset_n low, asynchronous): state=HOLD; all store words=0; load_addr=0; out_value=0; out_valid=0; out_count=0; release counter=0; cpu_reset=1.
- mem_data is combinational, with no registered latency. When cpu_bus[7:6]==2'b00, it equals store[cpu_bus[5:0]]; otherwise it is 0. The CPU samples data one clock after it registers the address, so a registered read is not allowed.
- States:
  - HOLD: entered only via reset. On the first clock after reset_n rises, load the release counter with RELEASE_CYCLES-1 and go to RELEASE. If load_mode=1, go to LOAD instead.
  - LOAD: on entry, load_addr=0. On each clock with load_valid=1, write store[load_addr]<=load_data and increment load_addr, wrapping 63->0. When load_mode=0, go to RELEASE with the counter reloaded. load_valid is ignored outside LOAD.
  - RELEASE: the counter decrements each clock. At 0, go to RUN. load_mode=1 goes to LOAD, and load_mode has priority over the count.
  - RUN: load_mode=1 goes to LOAD on the next clock.
- cpu_reset = 1 in every state except RUN. It is registered from the state, with no glitches. It deasserts exactly RELEASE_CYCLES clocks after the state leaves HOLD or LOAD.
- Display capture, in RUN only:
  - Registered flag prev_disp = (cpu_bus[7:6]==2'b10).
  - When the pattern is present and prev_disp=0 (rising edge), on that clock: out_value<=cpu_bus[5:0], out_valid<=1 for one cycle, out_count<=out_count+1.
  - out_count wraps at 2**OUT_CNT_W-1 -> 0.
  - A held pattern counts once. Bus values 2'b01 and 2'b11 in bits [7:6] are ignored.
- prev_disp is cleared outside RUN, so a pattern already present on the first RUN cycle is captured.
- Store writes happen only in LOAD, while the CPU is held in reset, so there is no read/write conflict. A combinational read during LOAD shows the new word after the write edge.
- Simultaneous load_mode rise and display edge in RUN: the capture still occurs on that clock, and the state moves to LOAD.
- reset_n asserted mid-load: the store is cleared to 0; a partial program is not retained.

Test Plan:
1. Reset then idle with load_mode=0 and RELEASE_CYCLES=4 -> cpu_reset=1 through the 4th clock after reset_n rises, then 0; mem_data=0 for every cpu_bus address 0x00..0x3F.
2. Load sequence 7,9,16,5,2 with load_valid back-to-back, then drop load_mode -> load_addr=5; cpu_bus=0x01 gives mem_data=9; cpu_bus=0x03 gives mem_data=5; cpu_reset is 1 during LOAD and falls 4 clocks after load_mode falls.
3. In RUN, drive cpu_bus=0x89 for 1 cycle, 0x02 for 3 cycles, then 0x89 for 2 cycles -> two out_valid pulses, out_value=9, out_count=2; mem_data=0 while cpu_bus=0x89.
4. Load 65 words (values i mod 64) -> load_addr wraps to 1; store[0]=0 (the 65th write), store[1]=1.
5. Pulse reset_n low mid-LOAD after 3 writes -> all outputs and store return to reset values immediately, with no clock needed; state returns to HOLD.
6. Preload out_count=255 via 255 display edges, then one more -> out_count=0 and out_valid pulses; cpu_bus=0xC5 and 0x45 produce no capture.

Source files
------------

// File: rtl/tt_cpu_prog_mem_responder.sv
// Memory-side responder for the 6-bit TinyTapeout accumulator CPU: serves
// fetches from a host-loaded program store, captures display words, sequences CPU reset.
module tt_cpu_prog_mem_responder #(
   parameter int unsigned ADDR_W         = 6,
   parameter int unsigned DATA_W         = 6,
   parameter int unsigned RELEASE_CYCLES = 4,
   parameter int unsigned OUT_CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [7:0]           cpu_bus,
   output logic [DATA_W-1:0]    mem_data,
   output logic                 cpu_reset,
   input  logic                 load_mode,
   input  logic                 load_valid,
   input  logic [DATA_W-1:0]    load_data,
   output logic [ADDR_W-1:0]    load_addr,
   output logic [DATA_W-1:0]    out_value,
   output logic                 out_valid,
   output logic [OUT_CNT_W-1:0] out_count
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      LOAD    = 2'd1,
      RELEASE = 2'd2,
      RUN     = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   rel_cnt;
   logic [DATA_W-1:0]  store [DEPTH];
   logic               prev_disp;

   logic               reload_c;
   logic               write_c;
   logic               enter_load_c;
   logic               disp_c;
   logic               disp_edge_c;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= HOLD;
      else          state <= state_nxt;
   end

   // Next state and per-cycle strobes; load_mode wins over the release count
   always_comb begin
      state_nxt    = state;
      reload_c     = 1'b0;
      write_c      = 1'b0;
      enter_load_c = 1'b0;
      disp_c       = (cpu_bus[7:6] == 2'b10);
      disp_edge_c  = 1'b0;
      case (state)
         HOLD: begin
            if (load_mode) begin
               state_nxt = LOAD;
            end else begin
               state_nxt = RELEASE;
               reload_c  = 1'b1;
            end
         end
         LOAD: begin
            write_c = load_valid;
            if (!load_mode) begin
               state_nxt = RELEASE;
               reload_c  = 1'b1;
            end
         end
         RELEASE: begin
            if (load_mode) begin
               state_nxt    = LOAD;
               enter_load_c = 1'b1;
            end else if (rel_cnt == '0) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            disp_edge_c = disp_c && !prev_disp;
            if (load_mode) begin
               state_nxt    = LOAD;
               enter_load_c = 1'b1;
            end
         end
         default: state_nxt = HOLD;
      endcase
   end

   // Release counter and CPU reset; cpu_reset tracks the next state so it drops with RUN entry
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rel_cnt   <= '0;
         cpu_reset <= 1'b1;
      end else begin
         if (reload_c)
            rel_cnt <= CNT_W'(RELEASE_CYCLES - 1);
         else if (state == RELEASE && rel_cnt != '0)
            rel_cnt <= rel_cnt - CNT_W'(1);
         cpu_reset <= (state_nxt != RUN);
      end
   end

   // Program store and write pointer; HOLD already leaves load_addr at zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         load_addr <= '0;
         for (int i = 0; i < int'(DEPTH); i++) store[i] <= '0;
      end else begin
         if (enter_load_c) begin
            load_addr <= '0;
         end else if (write_c) begin
            store[load_addr] <= load_data;
            load_addr        <= load_addr + ADDR_W'(1);
         end
      end
   end

   // Fetch response is combinational: the CPU samples it one clock after the address
   always_comb begin
      mem_data = '0;
      if (cpu_bus[7:6] == 2'b00) mem_data = store[cpu_bus[ADDR_W-1:0]];
   end

   // Display capture on the rising edge of the display pattern, RUN only
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_disp <= 1'b0;
         out_value <= '0;
         out_valid <= 1'b0;
         out_count <= '0;
      end else begin
         out_valid <= 1'b0;
         prev_disp <= (state == RUN) && disp_c;
         if (disp_edge_c) begin
            out_value <= cpu_bus[DATA_W-1:0];
            out_valid <= 1'b1;
            out_count <= out_count + OUT_CNT_W'(1);
         end
      end
   end

endmodule
